cr_prefix_fe_cmp_ctl: RTL and testbench
=======================================

Name: cr_prefix_fe_cmp_ctl

Overview:
Sequencer and configuration controller for a bank of N_CMP single-character prefix comparators in the prefix feature-extraction front end. It holds double-buffered per-comparator configuration: the shadow bank is written by software, and the active bank drives the comparators. It broadcasts each accepted input character to all comparators and ORs their registered results into a per-record hit vector. At each record end it reports the hit vector and character count to the downstream feature assembler over a valid/ready handshake.

Parameters:
N_CMP, 16, number of comparator slots driven by this controller.
IDX_W, 4, width of the config slot index; must satisfy 2^IDX_W >= N_CMP.
CNT_W, 16, width of the per-record character counter.

Ports:
clk  input  1  clock.
rst_n  input  1  reset, asynchronous, active-low.
cfg_wr  input  1  write strobe for one shadow slot.
cfg_idx  input  IDX_W  shadow slot index; writes with cfg_idx >= N_CMP are ignored.
cfg_match_val  input  8  match value for the slot.
cfg_cmp_type  input  2  compare type for the slot: 0=EQ, 1=GTEQ, 2=LT, 3=EQOP.
cfg_commit  input  1  request to copy shadow to active.
commit_pend  output  1  commit requested but not yet applied.
in_char  input  8  input character.
in_valid  input  1  character valid.
in_last  input  1  last character of record; qualified by in_valid.
in_ready  output  1  controller accepts the character this cycle.
cmp_char  output  8  character broadcast to all comparators.
cmp_char_valid  output  1  broadcast valid.
cmp_match_val  output  8*N_CMP  active match values; slot i at [8i+7:8i].
cmp_type  output  2*N_CMP  active compare types; slot i at [2i+1:2i].
cmp_res  input  N_CMP  registered comparator results, arriving 1 cycle after cmp_char_valid.
cmp_res_valid  input  1  registered char valid from the bank, aligned with cmp_res.
rep_valid  output  1  record report valid.
rep_ready  input  1  downstream accepts the report.
rep_hit  output  N_CMP  OR of all cmp_res seen during the record.
rep_cnt  output  CNT_W  characters in the record, saturating.

Behaviour:
- Reset: all shadow and active slots reset to match_val=0, type=EQ. All outputs are 0 and the FSM is in IDLE.
- Exception: in_ready is combinational from state and equals 0 during reset.
- Shadow writes are allowed in any state; write at edge when cfg_wr is high. Active slots change only on a swap.
- Commit handling:
  - cfg_commit sets commit_pend.
  - The swap occurs on the first clock edge where the FSM is in IDLE and commit_pend=1.
  - In that cycle in_ready=0, so no character is accepted, and commit_pend clears.
  - A cfg_wr coinciding with the swap edge is written to shadow only; it is not copied to active.
  - A cfg_commit coinciding with the swap edge leaves commit_pend=1.
- FSM states: IDLE, RUN, DRAIN, REPORT.
- IDLE:
  - in_ready = ~commit_pend.
  - On accept: go to RUN; set cnt=1 and clear the hit accumulator.
  - If in_last is set on that accept, go to DRAIN instead.
- RUN:
  - in_ready=1.
  - Each accept increments cnt, saturating at 2^CNT_W-1.
  - An accept with in_last goes to DRAIN.
- DRAIN:
  - in_ready=0.
  - Wait for the cmp_res_valid of the last character, i.e. the first cycle in DRAIN since comparator latency is 1.
  - Fold that result in, then go to REPORT.
- REPORT:
  - rep_valid=1; rep_hit and rep_cnt are held stable.
  - On rep_valid & rep_ready, go to IDLE the next cycle.
  - in_ready=0 throughout.
- Broadcast: cmp_char and cmp_char_valid are combinational from in_char and in_valid&in_ready. The comparators register internally.
- Accumulation: the hit accumulator ORs in cmp_res when cmp_res_valid=1, in RUN and DRAIN, and in IDLE for a result that belongs to the new record. The accumulator clears only on the first accept of a record.
- Configuration stability: the active config is constant from first accept to REPORT exit, because swaps happen only in IDLE.
- cmp_res_valid outside the expected cycles is ignored in REPORT.
- Reset mid-record drops the record; no report is produced.

Test Plan:
- Reset, then commit slot0={0x2F,EQ}, slot1={0x41,GTEQ}; stream "A/z" with last on 'z'. Required: rep_hit[1:0]=2'b11, rep_cnt=3, rep_valid held until rep_ready.
- Single-char record 'a' with in_last, comparator 1-cycle latency. Required: IDLE→DRAIN→REPORT, rep_cnt=1, rep_valid asserted 2 cycles after accept.
- cfg_commit asserted mid-record. Required: active config unchanged until the REPORT handshake; swap in the following IDLE cycle with in_ready=0 for exactly that cycle; commit_pend then falls.
- rep_ready held low 5 cycles. Required: in_ready=0 and in_valid ignored for those cycles; report fields stable; new record accepted the cycle after the handshake.
- Record of 70000 chars with CNT_W=16. Required: rep_cnt=65535 (saturated).
- rst_n asserted mid-RUN. Required: rep_valid=0, commit_pend=0, active slots back to {0,EQ}, FSM in IDLE.

Source files
------------

// File: rtl/cr_prefix_fe_cmp_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : cr_prefix_fe_cmp_ctl_if
// Description : Stream and report bundle for the prefix comparator controller.
//               The character stream is carried by in_char, in_valid, in_last
//               and in_ready. The per-record report is carried by rep_valid,
//               rep_ready, rep_hit and rep_cnt.
//               master : environment side. It drives the character stream and
//                        rep_ready, and it consumes the report.
//               slave  : controller side. It accepts characters and produces
//                        the report.
// Revision    : 1.0  initial release
// ============================================================================
interface cr_prefix_fe_cmp_ctl_if #(
    parameter int N_CMP = 16,
    parameter int CNT_W = 16
);
    logic [7:0]       in_char;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             rep_valid;
    logic             rep_ready;
    logic [N_CMP-1:0] rep_hit;
    logic [CNT_W-1:0] rep_cnt;

    modport master (
        output in_char, in_valid, in_last, rep_ready,
        input  in_ready, rep_valid, rep_hit, rep_cnt
    );

    modport slave (
        input  in_char, in_valid, in_last, rep_ready,
        output in_ready, rep_valid, rep_hit, rep_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cr_prefix_fe_cmp_ctl.sv
`default_nettype none
// ============================================================================
// Module      : cr_prefix_fe_cmp_ctl
// Description : Sequencer and configuration controller for a bank of N_CMP
//               single-character prefix comparators.
//               - Per-slot configuration is double-buffered. Software writes
//                 the shadow bank, and a commit copies the shadow bank into
//                 the active bank, but only while idle.
//               - Each accepted character is broadcast to every comparator.
//               - The registered comparator results are OR-accumulated into a
//                 per-record hit vector.
//               - At record end the hit vector and the saturating character
//                 count are offered downstream over valid/ready.
// Ports       : clk, rst_n            clock, async active-low reset
//               cfg_wr/idx/match_val/cmp_type
//                                     shadow slot write
//               cfg_commit            request shadow->active swap
//               commit_pend           swap requested but not yet applied
//               bus (slave)           character stream in, record report out
//               cmp_char/_valid       broadcast to the comparator bank
//               cmp_match_val/cmp_type
//                                     active per-slot configuration, flattened
//               cmp_res/_valid        registered comparator results
// Revision    : 1.0  initial release
// ============================================================================
module cr_prefix_fe_cmp_ctl #(
    parameter int N_CMP = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cfg_wr,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [7:0]            cfg_match_val,
    input  logic [1:0]            cfg_cmp_type,
    input  logic                  cfg_commit,
    output logic                  commit_pend,

    cr_prefix_fe_cmp_ctl_if.slave bus,

    output logic [7:0]            cmp_char,
    output logic                  cmp_char_valid,
    output logic [8*N_CMP-1:0]    cmp_match_val,
    output logic [2*N_CMP-1:0]    cmp_type,
    input  logic [N_CMP-1:0]      cmp_res,
    input  logic                  cmp_res_valid
);

    localparam logic [IDX_W:0]   C_N_CMP   = (IDX_W+1)'(N_CMP);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t           r_state;
    logic [7:0]       r_shd_val  [N_CMP];
    logic [1:0]       r_shd_type [N_CMP];
    logic [7:0]       r_act_val  [N_CMP];
    logic [1:0]       r_act_type [N_CMP];
    logic             r_commit_pend;
    logic [N_CMP-1:0] r_hit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rep_valid;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_swap;
    logic             w_cfg_wr_en;

    // ------------------------------------------------------------------
    // Ready is decoded straight from state. It is also forced low while
    // reset is held, so that nothing is accepted before the controller
    // is out of reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: w_in_ready = ~r_commit_pend;
                ST_RUN:  w_in_ready = 1'b1;
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    assign w_accept    = bus.in_valid & w_in_ready;
    // A pending commit holds off the next record for one idle cycle, so
    // the copy never overlaps a record.
    assign w_swap      = (r_state == ST_IDLE) & r_commit_pend;
    assign w_cfg_wr_en = cfg_wr & ({1'b0, cfg_idx} < C_N_CMP);

    // ------------------------------------------------------------------
    // Shadow / active configuration and the commit flag.
    // The active bank copies the pre-edge shadow contents. A shadow write
    // that lands on the same edge as the swap therefore stays in the
    // shadow bank until the next commit. A commit that lands on the swap
    // edge re-arms the flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CMP; i++) begin
                r_shd_val[i]  <= 8'h00;
                r_shd_type[i] <= 2'd0;
                r_act_val[i]  <= 8'h00;
                r_act_type[i] <= 2'd0;
            end
            r_commit_pend <= 1'b0;
        end else begin
            if (w_cfg_wr_en) begin
                r_shd_val[cfg_idx]  <= cfg_match_val;
                r_shd_type[cfg_idx] <= cfg_cmp_type;
            end
            if (w_swap) begin
                for (int i = 0; i < N_CMP; i++) begin
                    r_act_val[i]  <= r_shd_val[i];
                    r_act_type[i] <= r_shd_type[i];
                end
            end
            if (cfg_commit) begin
                r_commit_pend <= 1'b1;
            end else if (w_swap) begin
                r_commit_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Record sequencer. Comparator latency is one cycle.
    // - Results for characters accepted in RUN arrive while still in RUN,
    //   or in the first DRAIN cycle for the last character.
    // - Any result seen in IDLE belongs to the previous record, which was
    //   already folded in DRAIN. So IDLE only clears the accumulator, on
    //   the first accept of a new record.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hit       <= '0;
            r_cnt       <= '0;
            r_rep_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hit   <= '0;
                        r_cnt   <= CNT_W'(1);
                        r_state <= bus.in_last ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cmp_res_valid) begin
                        r_hit <= r_hit | cmp_res;
                    end
                    if (w_accept) begin
                        if (r_cnt != C_CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (bus.in_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cmp_res_valid) begin
                        r_hit       <= r_hit | cmp_res;
                        r_state     <= ST_REPORT;
                        r_rep_valid <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    // Fields are held; stray result strobes are ignored here.
                    if (bus.rep_ready) begin
                        r_state     <= ST_IDLE;
                        r_rep_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rep_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready   = w_in_ready;
    assign bus.rep_valid  = r_rep_valid;
    assign bus.rep_hit    = r_hit;
    assign bus.rep_cnt    = r_cnt;
    assign commit_pend    = r_commit_pend;

    // The broadcast character is zeroed when not accepted. This keeps the
    // bank input quiet between characters.
    assign cmp_char       = w_accept ? bus.in_char : 8'h00;
    assign cmp_char_valid = w_accept;

    for (genvar gi = 0; gi < N_CMP; gi++) begin : g_slot
        assign cmp_match_val[8*gi +: 8] = r_act_val[gi];
        assign cmp_type[2*gi +: 2]      = r_act_type[gi];
    end

endmodule
`default_nettype wire

// File: tb/tb_cr_prefix_fe_cmp_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cr_prefix_fe_cmp_ctl
// Description : Self-checking bench for cr_prefix_fe_cmp_ctl.
//               - A one-cycle comparator bank is modelled around the DUT.
//               - A transaction-level model predicts ready, commit, config
//                 and report values. A negedge process compares the DUT
//                 against that model every cycle.
//               - Directed scenarios add hand-computed literal checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cr_prefix_fe_cmp_ctl;

    localparam int N_CMP   = 16;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic             cfg_wr        = 1'b0;
    logic [IDX_W-1:0] cfg_idx       = '0;
    logic [7:0]       cfg_match_val = '0;
    logic [1:0]       cfg_cmp_type  = '0;
    logic             cfg_commit    = 1'b0;
    logic             commit_pend;
    logic [7:0]       cmp_char;
    logic             cmp_char_valid;
    logic [8*N_CMP-1:0] cmp_match_val;
    logic [2*N_CMP-1:0] cmp_type;
    logic [N_CMP-1:0] cmp_res       = '0;
    logic             cmp_res_valid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    cr_prefix_fe_cmp_ctl_if #(.N_CMP(N_CMP), .CNT_W(CNT_W)) bus ();

    cr_prefix_fe_cmp_ctl #(.N_CMP(N_CMP), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_wr         (cfg_wr),
        .cfg_idx        (cfg_idx),
        .cfg_match_val  (cfg_match_val),
        .cfg_cmp_type   (cfg_cmp_type),
        .cfg_commit     (cfg_commit),
        .commit_pend    (commit_pend),
        .bus            (bus.slave),
        .cmp_char       (cmp_char),
        .cmp_char_valid (cmp_char_valid),
        .cmp_match_val  (cmp_match_val),
        .cmp_type       (cmp_type),
        .cmp_res        (cmp_res),
        .cmp_res_valid  (cmp_res_valid)
    );

    always #5 clk = ~clk;

    // Compare semantics: 0=EQ, 1=GTEQ, 2=LT, 3=EQOP (treated as equality)
    function automatic logic cmp_fn(input logic [7:0] c, input logic [7:0] v, input logic [1:0] t);
        case (t)
            2'd1:    return c >= v;
            2'd2:    return c < v;
            default: return c == v;
        endcase
    endfunction

    // Comparator bank with one register stage
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_res       <= '0;
            cmp_res_valid <= 1'b0;
        end else begin
            cmp_res_valid <= cmp_char_valid;
            for (int i = 0; i < N_CMP; i++)
                cmp_res[i] <= cmp_char_valid && cmp_fn(cmp_char, cmp_match_val[8*i +: 8], cmp_type[2*i +: 2]);
        end
    end

    // ------------------------------------------------------------------
    // Reference model (transaction level)
    // ------------------------------------------------------------------
    logic [7:0]       m_shd_v [N_CMP];
    logic [1:0]       m_shd_t [N_CMP];
    logic [7:0]       m_act_v [N_CMP];
    logic [1:0]       m_act_t [N_CMP];
    bit               m_pend   = 0;
    bit               m_in_rec = 0;   // a record is open and accepting
    bit               m_drain  = 0;   // last char taken, result still in flight
    bit               m_rep    = 0;   // report on offer
    logic [N_CMP-1:0] m_hit    = '0;
    int               m_cnt    = 0;

    always @(posedge clk or negedge rst_n) begin : model_step
        bit idle_pre, ready_pre, acc, swap;
        if (!rst_n) begin
            for (int i = 0; i < N_CMP; i++) begin
                m_shd_v[i] = 8'h00; m_shd_t[i] = 2'd0;
                m_act_v[i] = 8'h00; m_act_t[i] = 2'd0;
            end
            m_pend = 0; m_in_rec = 0; m_drain = 0; m_rep = 0;
            m_hit = '0; m_cnt = 0;
        end else begin
            idle_pre  = !m_in_rec && !m_drain && !m_rep;
            ready_pre = (idle_pre && !m_pend) || m_in_rec;
            acc       = bus.in_valid && ready_pre;
            swap      = idle_pre && m_pend;
            if (m_rep && bus.rep_ready) m_rep = 0;
            if (m_drain) begin
                m_drain = 0;
                m_rep   = 1;
            end
            if (acc) begin
                if (idle_pre) begin
                    m_hit = '0;
                    m_cnt = 0;
                end
                for (int i = 0; i < N_CMP; i++)
                    if (cmp_fn(bus.in_char, m_act_v[i], m_act_t[i])) m_hit[i] = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                m_in_rec = !bus.in_last;
                m_drain  = bus.in_last;
            end
            if (swap) begin
                for (int i = 0; i < N_CMP; i++) begin
                    m_act_v[i] = m_shd_v[i];
                    m_act_t[i] = m_shd_t[i];
                end
            end
            if (cfg_commit) m_pend = 1;
            else if (swap)  m_pend = 0;
            if (cfg_wr && (int'(cfg_idx) < N_CMP)) begin
                m_shd_v[cfg_idx] = cfg_match_val;
                m_shd_t[cfg_idx] = cfg_cmp_type;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [8*N_CMP-1:0] exp_mv;
        logic [2*N_CMP-1:0] exp_ty;
        bit exp_ready;
        if (rst_n) begin
            for (int i = 0; i < N_CMP; i++) begin
                exp_mv[8*i +: 8] = m_act_v[i];
                exp_ty[2*i +: 2] = m_act_t[i];
            end
            exp_ready = (!m_in_rec && !m_drain && !m_rep && !m_pend) || m_in_rec;
            check("model in_ready", bus.in_ready, exp_ready);
            check("model commit_pend", commit_pend, m_pend);
            check("model rep_valid", bus.rep_valid, m_rep);
            check("model cmp_match_val", cmp_match_val, exp_mv);
            check("model cmp_type", cmp_type, exp_ty);
            if (m_rep) begin
                check("model rep_hit", bus.rep_hit, m_hit);
                check("model rep_cnt", bus.rep_cnt, m_cnt[CNT_W-1:0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input logic [7:0] v, input logic [1:0] t);
        cfg_wr = 1'b1; cfg_idx = idx[IDX_W-1:0]; cfg_match_val = v; cfg_cmp_type = t;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input logic last);
        int k;
        k = 0;
        bus.in_char = c; bus.in_last = last; bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!bus.in_ready) begin
            n_checks++; n_errors++;
            $display("FAIL send timeout: in_ready=0, expected 1 within 50 cycles");
        end
        tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic wait_rep(input string name);
        int k;
        k = 0;
        while (!bus.rep_valid && k < 50) begin
            tick();
            k++;
        end
        if (!bus.rep_valid) begin
            n_checks++; n_errors++;
            $display("FAIL %s timeout: rep_valid=0, expected 1 within 50 cycles", name);
        end
    endtask

    task automatic handshake();
        bus.rep_ready = 1'b1;
        tick();
        bus.rep_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        bus.in_char = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.rep_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", bus.in_ready, 0);
        check("reset rep_valid", bus.rep_valid, 0);
        check("reset commit_pend", commit_pend, 0);
        check("reset cmp_match_val", cmp_match_val, 0);
        check("reset cmp_type", cmp_type, 0);
        rst_n = 1'b1;
        tick();

        // Scenario 1: "A/z" with slot0={2F,EQ}, slot1={41,GTEQ}
        cfg_write(0, 8'h2F, 2'd0);
        cfg_write(1, 8'h41, 2'd1);
        commit();
        send("A", 1'b0);
        send("/", 1'b0);
        send("z", 1'b1);
        wait_rep("s1");
        check("s1 rep_hit", bus.rep_hit, 16'h0003);
        check("s1 rep_cnt", bus.rep_cnt, 3);
        tick(); tick();
        check("s1 rep_valid held", bus.rep_valid, 1);
        handshake();

        // Scenario 2: single-character record 'a'
        send("a", 1'b1);
        check("s2 rep_valid accept+1", bus.rep_valid, 0);
        tick();
        check("s2 rep_valid accept+2", bus.rep_valid, 1);
        check("s2 rep_hit", bus.rep_hit, 16'h0002);
        check("s2 rep_cnt", bus.rep_cnt, 1);
        handshake();

        // Scenario 3: commit requested mid-record
        cfg_write(0, 8'h7A, 2'd0);
        send("x", 1'b0);
        commit();
        send("y", 1'b0);
        send("z", 1'b1);
        wait_rep("s3");
        check("s3 rep_hit", bus.rep_hit, 16'h0002);
        check("s3 slot0 before swap", cmp_match_val[7:0], 8'h2F);
        handshake();
        check("s3 idle in_ready", bus.in_ready, 0);
        check("s3 idle commit_pend", commit_pend, 1);
        check("s3 idle slot0 old", cmp_match_val[7:0], 8'h2F);
        tick();
        check("s3 post-swap in_ready", bus.in_ready, 1);
        check("s3 post-swap commit_pend", commit_pend, 0);
        check("s3 post-swap slot0", cmp_match_val[7:0], 8'h7A);

        // Scenario 4: report back-pressure for five cycles
        send("b", 1'b0);
        send("c", 1'b1);
        wait_rep("s4");
        bus.in_char = "q"; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("s4 stall rep_valid", bus.rep_valid, 1);
            check("s4 stall in_ready", bus.in_ready, 0);
            check("s4 stall rep_cnt", bus.rep_cnt, 2);
            check("s4 stall rep_hit", bus.rep_hit, 16'h0002);
            tick();
        end
        handshake();
        check("s4 after handshake in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        check("s4 new record draining", bus.rep_valid, 0);
        wait_rep("s4b");
        check("s4b rep_cnt", bus.rep_cnt, 1);
        handshake();

        // Scenario 5: 70000-character record saturates the count
        for (int i = 0; i < 70000; i++)
            send("z", (i == 69999));
        wait_rep("s5");
        check("s5 rep_cnt saturated", bus.rep_cnt, 16'hFFFF);
        check("s5 rep_hit", bus.rep_hit, 16'h0003);
        handshake();

        // Scenario 6: reset in the middle of a record with a commit pending
        send("m", 1'b0);
        send("n", 1'b0);
        cfg_write(2, 8'h55, 2'd2);
        commit();
        #2 rst_n = 1'b0;
        #1;
        check("s6 reset rep_valid", bus.rep_valid, 0);
        check("s6 reset commit_pend", commit_pend, 0);
        check("s6 reset in_ready", bus.in_ready, 0);
        check("s6 reset cmp_match_val", cmp_match_val, 0);
        check("s6 reset cmp_type", cmp_type, 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("s6 no report after reset", bus.rep_valid, 0);
        check("s6 idle in_ready", bus.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
